// File: rtl/spi_master_ctrl_pkg.sv
// Shared types and encodings for the SPI master transaction sequencer.
package spi_pkg;

  localparam int CNT_W_DEF  = 16;
  localparam int CS_NUM_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_ADDR  = 3'd2,
    ST_DUMMY = 3'd3,
    ST_WDATA = 3'd4,
    ST_RDATA = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

  localparam logic [1:0] SEL_CMD  = 2'd0;
  localparam logic [1:0] SEL_ADDR = 2'd1;
  localparam logic [1:0] SEL_FIFO = 2'd2;

endpackage

// File: rtl/spi_master_ctrl_if.sv
// Config, shifter handshake and SPI-side outputs of the transaction sequencer.
interface spi_master_ctrl_if #(
  parameter int CS_NUM = 4,
  parameter int CNT_W  = 16
);
  logic              start;
  logic [31:0]       cfg_cmd;
  logic [5:0]        cfg_cmd_len;
  logic [31:0]       cfg_addr;
  logic [5:0]        cfg_addr_len;
  logic [CNT_W-1:0]  cfg_dummy;
  logic [CNT_W-1:0]  cfg_wr_len;
  logic [CNT_W-1:0]  cfg_rd_len;
  logic              cfg_quad;
  logic [CS_NUM-1:0] cfg_csreg;
  logic              spi_edge;
  logic              tx_done;
  logic              rx_done;
  logic              tx_clk_en;
  logic              rx_clk_en;
  logic              tx_en;
  logic [CNT_W-1:0]  tx_cnt;
  logic              tx_cnt_upd;
  logic              tx_quad;
  logic [1:0]        tx_sel;
  logic [31:0]       tx_word;
  logic              rx_en;
  logic [CNT_W-1:0]  rx_cnt;
  logic              rx_cnt_upd;
  logic              rx_quad;
  logic              spi_clk_en;
  logic [CS_NUM-1:0] cs_n;
  logic              busy;
  logic              eot;

  modport master (
    input  start, cfg_cmd, cfg_cmd_len, cfg_addr, cfg_addr_len, cfg_dummy,
           cfg_wr_len, cfg_rd_len, cfg_quad, cfg_csreg, spi_edge, tx_done,
           rx_done, tx_clk_en, rx_clk_en,
    output tx_en, tx_cnt, tx_cnt_upd, tx_quad, tx_sel, tx_word, rx_en, rx_cnt,
           rx_cnt_upd, rx_quad, spi_clk_en, cs_n, busy, eot
  );

  modport slave (
    output start, cfg_cmd, cfg_cmd_len, cfg_addr, cfg_addr_len, cfg_dummy,
           cfg_wr_len, cfg_rd_len, cfg_quad, cfg_csreg, spi_edge, tx_done,
           rx_done, tx_clk_en, rx_clk_en,
    input  tx_en, tx_cnt, tx_cnt_upd, tx_quad, tx_sel, tx_word, rx_en, rx_cnt,
           rx_cnt_upd, rx_quad, spi_clk_en, cs_n, busy, eot
  );
endinterface

// File: rtl/spi_master_ctrl_phase_sel.sv
// Picks the first phase after i_cur whose length is nonzero; DONE if none remain.
module spi_phase_sel
  import spi_pkg::*;
(
  input  state_t     i_cur,
  input  logic [4:0] i_nz,   // bit 0 = CMD ... bit 4 = RDATA
  output state_t     o_next
);

  always_comb begin
    o_next = ST_DONE;
    for (int i = 4; i >= 0; i--) begin
      if (i_nz[i] && ((i + 1) > int'(i_cur))) begin
        o_next = state_t'(3'(i + 1));
      end
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master transaction sequencer: runs CMD/ADDR/DUMMY/WDATA/RDATA phases of one
// latched transaction, driving shifter enables, counts, chip-select and clock enable.
//   state | meaning
//   IDLE  | waiting for start, cs released
//   CMD   | shifting command word out
//   ADDR  | shifting address word out
//   DUMMY | free-running SPI clock for cfg_dummy edges
//   WDATA | shifting write FIFO data out
//   RDATA | shifting read data in
//   DONE  | one-cycle eot, cs released
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int CS_NUM = CS_NUM_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input logic               clk,
  input logic               rstn,
  spi_master_ctrl_if.master bus
);

  state_t            r_state;
  state_t            w_next;
  state_t            w_pick;
  logic              r_entry;
  logic [CNT_W-1:0]  r_dcnt;
  logic [31:0]       r_cmd;
  logic [5:0]        r_cmd_len;
  logic [31:0]       r_addr;
  logic [5:0]        r_addr_len;
  logic [CNT_W-1:0]  r_dummy;
  logic [CNT_W-1:0]  r_wr_len;
  logic [CNT_W-1:0]  r_rd_len;
  logic              r_quad;
  logic [CS_NUM-1:0] r_csreg;
  logic [4:0]        w_nz;
  logic              w_tx_done;
  logic              w_rx_done;
  logic              w_dummy_end;

  // In IDLE the picker must see the live config, since latching happens on the same edge.
  always_comb begin
    if (r_state == ST_IDLE) begin
      w_nz = {|bus.cfg_rd_len, |bus.cfg_wr_len, |bus.cfg_dummy,
              |bus.cfg_addr_len, |bus.cfg_cmd_len};
    end else begin
      w_nz = {|r_rd_len, |r_wr_len, |r_dummy, |r_addr_len, |r_cmd_len};
    end
  end

  spi_phase_sel u_phase_sel (
    .i_cur  (r_state),
    .i_nz   (w_nz),
    .o_next (w_pick)
  );

  // Done strobes on the entry cycle precede the shifter load, so they are masked.
  assign w_tx_done   = bus.tx_done && !r_entry;
  assign w_rx_done   = bus.rx_done && !r_entry;
  assign w_dummy_end = bus.spi_edge && (r_dcnt == (r_dummy - 1'b1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (bus.start) w_next = w_pick;
      ST_CMD, ST_ADDR, ST_WDATA:
                if (w_tx_done) w_next = w_pick;
      ST_DUMMY: if (w_dummy_end) w_next = w_pick;
      ST_RDATA: if (w_rx_done) w_next = w_pick;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
      r_entry <= 1'b0;
      r_dcnt  <= '0;
    end else begin
      r_state <= w_next;
      r_entry <= (w_next != r_state);
      if (w_next == ST_DUMMY && r_state != ST_DUMMY) begin
        r_dcnt <= '0;
      end else if (r_state == ST_DUMMY && bus.spi_edge) begin
        r_dcnt <= r_dcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cmd      <= '0;
      r_cmd_len  <= '0;
      r_addr     <= '0;
      r_addr_len <= '0;
      r_dummy    <= '0;
      r_wr_len   <= '0;
      r_rd_len   <= '0;
      r_quad     <= 1'b0;
      r_csreg    <= '0;
    end else if (r_state == ST_IDLE && bus.start) begin
      r_cmd      <= bus.cfg_cmd;
      r_cmd_len  <= bus.cfg_cmd_len;
      r_addr     <= bus.cfg_addr;
      r_addr_len <= bus.cfg_addr_len;
      r_dummy    <= bus.cfg_dummy;
      r_wr_len   <= bus.cfg_wr_len;
      r_rd_len   <= bus.cfg_rd_len;
      r_quad     <= bus.cfg_quad;
      r_csreg    <= bus.cfg_csreg;
    end
  end

  logic              w_tx_en;
  logic [CNT_W-1:0]  w_tx_cnt;
  logic              w_tx_upd;
  logic              w_tx_quad;
  logic [1:0]        w_tx_sel;
  logic [31:0]       w_tx_word;
  logic              w_rx_en;
  logic [CNT_W-1:0]  w_rx_cnt;
  logic              w_rx_upd;
  logic              w_rx_quad;
  logic              w_dummy;
  logic [CS_NUM-1:0] w_cs_n;
  logic              w_eot;

  always_comb begin
    w_tx_en   = 1'b0;
    w_tx_cnt  = '0;
    w_tx_upd  = 1'b0;
    w_tx_quad = 1'b0;
    w_tx_sel  = SEL_CMD;
    w_tx_word = '0;
    w_rx_en   = 1'b0;
    w_rx_cnt  = '0;
    w_rx_upd  = 1'b0;
    w_rx_quad = 1'b0;
    w_dummy   = 1'b0;
    w_cs_n    = '1;
    w_eot     = 1'b0;
    case (r_state)
      ST_CMD: begin
        w_tx_en   = !w_tx_done;
        w_tx_upd  = r_entry;
        w_tx_cnt  = CNT_W'(r_cmd_len);
        w_tx_sel  = SEL_CMD;
        w_tx_word = r_cmd;
        w_cs_n    = ~r_csreg;
      end
      ST_ADDR: begin
        w_tx_en   = !w_tx_done;
        w_tx_upd  = r_entry;
        w_tx_cnt  = CNT_W'(r_addr_len);
        w_tx_sel  = SEL_ADDR;
        w_tx_word = r_addr;
        w_cs_n    = ~r_csreg;
      end
      ST_DUMMY: begin
        w_dummy = 1'b1;
        w_cs_n  = ~r_csreg;
      end
      ST_WDATA: begin
        w_tx_en   = !w_tx_done;
        w_tx_upd  = r_entry;
        w_tx_cnt  = r_wr_len;
        w_tx_sel  = SEL_FIFO;
        w_tx_quad = r_quad;
        w_cs_n    = ~r_csreg;
      end
      ST_RDATA: begin
        w_rx_en   = !w_rx_done;
        w_rx_upd  = r_entry;
        w_rx_cnt  = r_rd_len;
        w_rx_quad = r_quad;
        w_cs_n    = ~r_csreg;
      end
      ST_DONE: w_eot = 1'b1;
      default: ;
    endcase
  end

  assign bus.tx_en      = w_tx_en;
  assign bus.tx_cnt     = w_tx_cnt;
  assign bus.tx_cnt_upd = w_tx_upd;
  assign bus.tx_quad    = w_tx_quad;
  assign bus.tx_sel     = w_tx_sel;
  assign bus.tx_word    = w_tx_word;
  assign bus.rx_en      = w_rx_en;
  assign bus.rx_cnt     = w_rx_cnt;
  assign bus.rx_cnt_upd = w_rx_upd;
  assign bus.rx_quad    = w_rx_quad;
  assign bus.spi_clk_en = (w_tx_en & bus.tx_clk_en) | (w_rx_en & bus.rx_clk_en) | w_dummy;
  assign bus.cs_n       = w_cs_n;
  assign bus.busy       = (r_state != ST_IDLE);
  assign bus.eot        = w_eot;

endmodule

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
Transaction sequencer for the SPI master datapath. It takes one register-programmed transaction and runs its phases in a fixed order: command, address, dummy, write data, read data. In each phase it drives the TX/RX shifter enables, bit-count targets and data-source selection. It also owns chip-select and the SPI clock-enable merge, and reports busy and end-of-transfer to the register/IRQ layer.

Parameters:
CS_NUM, 4, number of chip-select lines
CNT_W, 16, width of bit-length fields and shifter counters

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
start  in  1  one-cycle transaction request; ignored unless idle
cfg_cmd  in  32  command word, MSB-aligned shift order
cfg_cmd_len  in  6  command bits, 0..32; 0 skips the phase
cfg_addr  in  32  address word
cfg_addr_len  in  6  address bits, 0..32; 0 skips the phase
cfg_dummy  in  CNT_W  dummy SPI clock edges; 0 skips the phase
cfg_wr_len  in  CNT_W  write-data bits; 0 skips the phase
cfg_rd_len  in  CNT_W  read-data bits; 0 skips the phase
cfg_quad  in  1  quad mode for data phases only
cfg_csreg  in  CS_NUM  one-hot chip select
spi_edge  in  1  SPI clock edge strobe from the clock generator
tx_done  in  1  TX shifter reached its target
rx_done  in  1  RX shifter reached its target
tx_clk_en  in  1  clock request from TX shifter
rx_clk_en  in  1  clock request from RX shifter
tx_en  out  1  TX shifter enable
tx_cnt  out  CNT_W  TX bit target
tx_cnt_upd  out  1  load strobe for tx_cnt
tx_quad  out  1  quad mode to TX
tx_sel  out  2  TX data source: 0 cmd, 1 addr, 2 write FIFO
tx_word  out  32  cmd or addr word, valid when tx_sel is 0 or 1
rx_en  out  1  RX shifter enable
rx_cnt  out  CNT_W  RX bit target
rx_cnt_upd  out  1  load strobe for rx_cnt
rx_quad  out  1  quad mode to RX
spi_clk_en  out  1  SPI clock enable to the clock generator
cs_n  out  CS_NUM  active-low chip selects
busy  out  1  transaction in progress
eot  out  1  one-cycle end-of-transfer pulse

Behaviour:
- Reset values: all outputs 0 except cs_n all-ones. FSM in IDLE, dummy counter 0, latched config cleared.
- States: IDLE, CMD, ADDR, DUMMY, WDATA, RDATA, DONE.
- IDLE with start=1: latch all cfg_* into internal registers, set busy=1 next cycle, and go to the first phase with nonzero length.
  - Phase order: CMD, ADDR, DUMMY, WDATA, RDATA.
  - If all lengths are 0, go straight to DONE.
- Phase entry, i.e. the first cycle in a state:
  - Pulse tx_cnt_upd or rx_cnt_upd for exactly 1 cycle with the phase length on tx_cnt/rx_cnt.
  - The matching tx_en/rx_en goes high in the same cycle and stays high for the whole phase.
- CMD: tx_sel=0, tx_word=latched cmd, tx_quad=0.
- ADDR: tx_sel=1, tx_word=latched addr, tx_quad=0.
- WDATA: tx_sel=2, tx_quad=latched quad.
- CMD, ADDR and WDATA exit on tx_done. On exit, drop tx_en in that same cycle and enter the next nonzero phase on the next cycle.
- DUMMY:
  - Internal counter clears on entry and increments on each spi_edge.
  - Exit when counter == cfg_dummy-1 and spi_edge are both high.
  - spi_clk_en is forced to 1 throughout.
- RDATA: rx_quad=latched quad; exit on rx_done. The controller does not divide the count for quad; the shifters do that.
- spi_clk_en = (tx_en & tx_clk_en) | (rx_en & rx_clk_en) | (state==DUMMY). This lets shifter backpressure (FIFO full/empty) stall the SPI clock transparently.
- cs_n = ~latched csreg in every state except IDLE and DONE; all-ones otherwise.
- DONE lasts exactly 1 cycle: eot=1, cs_n deasserted, busy still 1. Next cycle: IDLE, busy=0.
- Simultaneous events:
  - start during busy is dropped, not queued.
  - A done strobe arriving on the entry/upd cycle is ignored; the shifter counter is not yet loaded.
  - tx_done and rx_done are only sampled in their own phases.
- cfg_* changes while busy have no effect (latched).
- rstn asserted mid-transfer: immediate return to reset values, cs_n released asynchronously.

Decomposition:
- Package spi_pkg: state enum (3-bit), tx_sel encodings (SEL_CMD, SEL_ADDR, SEL_FIFO), CNT_W default.
- One natural sub-module, spi_phase_sel: combinational "next nonzero phase" priority picker, fed by the current phase and the five latched lengths.
- Everything else stays in the top FSM.

Test Plan:
- cmd_len=8 (0x9F), rd_len=24, all others 0, csreg=0001: cs_n=1110 for the whole transfer; the controller passes rx_cnt=24; the RX shifter's rx_done then strobes after 24 spi_edge; eot arrives 1 cycle after rx_done; the cycle after eot has busy=0.
- Quad read: cmd 8, addr 24, dummy 8, rd 32, quad=1: tx_quad=0 in CMD/ADDR; exactly 8 spi_edge in DUMMY with spi_clk_en=1; rx_cnt=32 with rx_quad=1.
- Write: cmd 8, wr_len=64, TX FIFO stalled by holding tx_clk_en=0 for 10 cycles mid-phase: spi_clk_en=0 during the stall, state stays WDATA, no eot.
- All lengths 0, start: IDLE→DONE→IDLE; eot=1 for 1 cycle; cs_n never asserted.
- start pulsed again while busy, and cfg_cmd changed mid-CMD: second start ignored; tx_word keeps its latched value.
- rstn pulled low during ADDR: cs_n=1111, busy=0, tx_en=0 immediately; the next start runs a clean transfer.
